// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives a fixed-latency BRAM,
// buffers tagged returning words and hands them to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ADDR_WIDTH   = 16,
    parameter int          BRAM_LATENCY = 2,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    output logic [ADDR_WIDTH-1:0] imem_addr_out,
    input  logic [31:0]           imem_data_in,
    input  logic                  redirect_in,
    input  logic [31:0]           redirect_pc_in,
    output logic                  inst_valid_out,
    input  logic                  inst_ready_in,
    output logic [31:0]           inst_out,
    output logic [31:0]           pc_out,
    output logic                  halted_out
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + BRAM_LATENCY + 1);
    localparam int LAST  = BRAM_LATENCY - 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    if (FIFO_DEPTH < BRAM_LATENCY + 1) begin : g_bad_depth
        $error("fetch_unit: FIFO_DEPTH must be at least BRAM_LATENCY+1");
    end

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [31:0]             fpc;
    logic                    epoch;
    logic [BRAM_LATENCY-1:0] sr_valid;
    logic [BRAM_LATENCY-1:0] sr_epoch;
    logic [31:0]             sr_pc [BRAM_LATENCY];

    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] inflight_count;

    logic        fifo_empty;
    logic        head_zero;
    logic        credits_ok;
    logic        issue;
    logic        push;
    logic        pop;
    logic [31:0] head_inst;
    logic [31:0] head_pc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            inflight_count = inflight_count + CNT_W'(sr_valid[i]);
        end
    end

    assign fifo_empty = (fifo_count == '0);
    assign head_inst  = fifo_inst[rd_ptr];
    assign head_pc    = fifo_pc[rd_ptr];
    assign head_zero  = !fifo_empty && (head_inst == 32'h0);

    assign inst_valid_out = !fifo_empty && !head_zero;
    assign inst_out       = fifo_empty ? 32'h0 : head_inst;
    assign pc_out         = fifo_empty ? 32'h0 : head_pc;
    assign halted_out     = (state == HALT) || head_zero;
    assign imem_addr_out  = fpc[ADDR_WIDTH+1:2];

    // Every outstanding request already owns a FIFO slot, so returns never overflow.
    assign credits_ok = (fifo_count + inflight_count) < CNT_W'(FIFO_DEPTH);
    assign issue      = (state == RUN) && !head_zero && credits_ok && !redirect_in;
    assign pop        = inst_valid_out && inst_ready_in;
    assign push       = sr_valid[LAST] && (sr_epoch[LAST] == epoch) && !redirect_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (head_zero && !redirect_in) state_next = HALT;
            HALT:    if (redirect_in) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fpc        <= RESET_PC;
            epoch      <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (redirect_in) begin
            // Flipping the epoch turns every request still in the BRAM pipe stale.
            fpc        <= redirect_pc_in & 32'hFFFF_FFFC;
            epoch      <= ~epoch;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (issue) fpc <= fpc + 32'd4;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sr_valid <= '0;
            sr_epoch <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) sr_pc[i] <= 32'h0;
        end else begin
            sr_valid[0] <= issue;
            sr_epoch[0] <= epoch;
            sr_pc[0]    <= fpc;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_epoch[i] <= sr_epoch[i-1];
                sr_pc[i]    <= sr_pc[i-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem_data_in;
            fifo_pc[wr_ptr]   <= sr_pc[LAST];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: BRAM model plus an architectural stream model (next expected
// PC, halt on a zero word, restart on redirect), directed scenarios and a random run.
module tb_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [15:0] imem_addr_out;
    logic [31:0] imem_data_in = 32'h0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'h0;
    logic        inst_valid_out;
    logic        inst_ready_in = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        halted_out;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .ADDR_WIDTH(16),
        .BRAM_LATENCY(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .imem_addr_out(imem_addr_out),
        .imem_data_in(imem_data_in),
        .redirect_in(redirect_in),
        .redirect_pc_in(redirect_pc_in),
        .inst_valid_out(inst_valid_out),
        .inst_ready_in(inst_ready_in),
        .inst_out(inst_out),
        .pc_out(pc_out),
        .halted_out(halted_out)
    );

    always #5 clk_in = ~clk_in;

    // Two-cycle read latency: address registered, then output registered.
    logic [31:0] mem [1024];
    logic [31:0] bram_stage = 32'h0;
    always @(posedge clk_in) begin
        bram_stage   <= mem[imem_addr_out[9:0]];
        imem_data_in <= bram_stage;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gap = 0;
    int max_gap = 0;
    int deliveries = 0;
    logic [31:0] exp_pc = 32'h0;
    logic        obs_valid;
    logic        obs_halted;
    logic [31:0] obs_pc;
    logic [31:0] obs_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return mem[pc[11:2]];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Drives one cycle's inputs, checks outputs against the stream model, advances a cycle.
    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] target);
        logic [31:0] want;
        inst_ready_in  = ready;
        redirect_in    = redir;
        redirect_pc_in = target;
        #1;
        obs_valid  = inst_valid_out;
        obs_halted = halted_out;
        obs_pc     = pc_out;
        obs_addr   = 32'(imem_addr_out);
        want       = mem_word(exp_pc);
        if (obs_valid || obs_halted) begin
            checkOutput("stream_pc", pc_out, exp_pc);
            checkOutput("stream_inst", inst_out, want);
            checkOutput("stream_halt", 32'(halted_out), 32'(want == 32'h0));
        end
        if (ready && !redir && !obs_valid && !obs_halted) gap++;
        else gap = 0;
        if (gap > max_gap) max_gap = gap;
        if (obs_valid && ready) begin
            exp_pc = exp_pc + 32'd4;
            deliveries++;
        end
        if (redir) exp_pc = target & 32'hFFFF_FFFC;
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(inst_valid_out), 32'h0);
        checkOutput({tag, "_inst"}, inst_out, 32'h0);
        checkOutput({tag, "_pc"}, pc_out, 32'h0);
        checkOutput({tag, "_halted"}, 32'(halted_out), 32'h0);
        checkOutput({tag, "_addr"}, 32'(imem_addr_out), 32'h0);
    endtask

    task automatic resetDut();
        rst_in         = 1'b0;
        inst_ready_in  = 1'b0;
        redirect_in    = 1'b0;
        redirect_pc_in = 32'h0;
        @(negedge clk_in);
        #1;
        checkResetOutputs("reset");
        @(negedge clk_in);
        rst_in = 1'b1;
        cyc    = 0;
        exp_pc = 32'h0;
        gap    = 0;
    endtask

    initial begin
        int valid_cnt;
        int pc8_cnt;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0010_0093 + i;

        $display("[TB] test 1: reset release and streaming");
        resetDut();
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput($sformatf("t1_valid_c%0d", c), 32'(obs_valid), 32'(c >= 3));
            if (c == 3) checkOutput("t1_first_pc", obs_pc, 32'h0);
            if (c == 10) checkOutput("t1_pc_c10", obs_pc, 32'h1C);
        end

        $display("[TB] test 2: consumer stall cycles 4-13");
        resetDut();
        valid_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(!(c >= 4 && c <= 13), 1'b0, 32'h0);
            if (c == 13) begin
                checkOutput("t2_fetch_limit", obs_addr, 32'd5);
                checkOutput("t2_held_pc", obs_pc, 32'h4);
            end
            if (c >= 14 && c <= 21 && obs_valid) valid_cnt++;
        end
        checkOutput("t2_no_gap", 32'(valid_cnt), 32'd8);

        $display("[TB] test 3: redirect at cycle 6");
        resetDut();
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, c == 6, 32'h0000_0042);
            if (c >= 7 && c <= 9) checkOutput($sformatf("t3_bubble_c%0d", c), 32'(obs_valid), 32'h0);
            if (c == 10) begin
                checkOutput("t3_target_valid", 32'(obs_valid), 32'h1);
                checkOutput("t3_target_pc", obs_pc, 32'h40);
            end
        end

        $display("[TB] test 4: zero word halts fetch");
        mem[4] = 32'h0;
        resetDut();
        valid_cnt = 0;
        for (int c = 0; c < 31; c++) begin
            applyStimulus(1'b1, c == 20, 32'h0);
            if (c < 20 && obs_valid) valid_cnt++;
            if (c == 19) checkOutput("t4_halted", 32'(obs_halted), 32'h1);
            if (c == 21) checkOutput("t4_unhalted", 32'(obs_halted), 32'h0);
            if (c == 24) begin
                checkOutput("t4_restart_valid", 32'(obs_valid), 32'h1);
                checkOutput("t4_restart_pc", obs_pc, 32'h0);
            end
        end
        checkOutput("t4_delivered", 32'(valid_cnt), 32'd4);
        mem[4] = 32'h0010_0093 + 4;

        $display("[TB] test 5: redirect with coincident handshake");
        resetDut();
        pc8_cnt = 0;
        for (int c = 0; c < 13; c++) begin
            applyStimulus(1'b1, c == 5, 32'h0000_0100);
            if (obs_valid && obs_pc == 32'h8) pc8_cnt++;
            if (c == 9) checkOutput("t5_target_pc", obs_pc, 32'h100);
        end
        checkOutput("t5_pc8_once", 32'(pc8_cnt), 32'd1);

        $display("[TB] test 6: asynchronous reset mid-stream");
        resetDut();
        for (int c = 0; c < 7; c++) applyStimulus(1'b1, 1'b0, 32'h0);
        #2;
        rst_in = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        @(negedge clk_in);
        rst_in = 1'b1;
        cyc    = 0;
        exp_pc = 32'h0;
        gap    = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            if (c == 3) checkOutput("t6_restart_pc", obs_pc, 32'h0);
        end

        $display("[TB] random phase");
        for (int i = 0; i < 1024; i++) begin
            mem[i] = ($urandom_range(0, 99) < 3) ? 32'h0 : ($urandom | 32'h1);
        end
        resetDut();
        deliveries = 0;
        max_gap    = 0;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 4,
                          32'($urandom_range(0, 4095)));
        end
        checkOutput("rand_max_gap", 32'(max_gap <= 5), 32'h1);
        checkOutput("rand_progress", 32'(deliveries > 300), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the processor core. Owns the program counter, drives the instruction BRAM (fixed read latency, always enabled), tags and buffers returning words, and presents them to decode over a valid/ready handshake. It sits directly upstream of decode/execute and replaces the fixed-period pulse scheme with a stall-tolerant, redirectable fetch stream.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- ADDR_WIDTH, 16, width of the BRAM word index.
- BRAM_LATENCY, 2, cycles from address presented to data valid on imem_data_in; HIGH_PERFORMANCE BRAM gives 2.
- FIFO_DEPTH, 4, instruction buffer entries; must be ≥ BRAM_LATENCY+1 (elaboration error otherwise).
- clk_in  input  1  single system clock, all logic on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- imem_addr_out  output  ADDR_WIDTH  BRAM word address, equal to pc[ADDR_WIDTH+1:2].
- imem_data_in  input  32  BRAM read data, BRAM_LATENCY cycles after address.
- redirect_in  input  1  one-cycle request to restart fetch at redirect_pc_in (taken branch/jump).
- redirect_pc_in  input  32  redirect byte address; bits [1:0] ignored (forced to 0).
- inst_valid_out  output  1  inst_out/pc_out hold a valid instruction.
- inst_ready_in  input  1  consumer accepts this cycle.
- inst_out  output  32  instruction word.
- pc_out  output  32  byte address of inst_out.
- halted_out  output  1  a 32'h0000_0000 word reached the head; fetch stopped.

## Operation
- Fetch PC register (fpc) drives imem_addr_out every cycle. A request "issues" in a cycle when credits > 0 and not halted; fpc then advances by 4 (32-bit wrap, no saturation).
- Credits = FIFO_DEPTH − FIFO occupancy − requests in flight. Guarantees every returning word has a FIFO slot; no response is ever dropped for lack of space.
- In-flight tracking: BRAM_LATENCY-deep shift register of {valid, epoch, pc}. When a valid entry exits with epoch equal to the current epoch, {imem_data_in, pc} is pushed into the FIFO; stale-epoch entries are discarded.
- Output: FIFO head drives inst_out/pc_out; inst_valid_out = FIFO non-empty and head word ≠ 0. Pop on inst_valid_out && inst_ready_in.
- Halt: head word 32'h0 is never delivered. halted_out asserts the cycle it is at head; issuing stops; FIFO holds. Cleared only by redirect or reset.
- Redirect (redirect_in=1 in cycle t): epoch toggles, FIFO cleared, halted_out cleared, fpc ← {redirect_pc_in[31:2],2'b00}; no request issues in cycle t. A handshake completing in cycle t is honoured (that instruction is consumed), then the flush applies.
- States: RUN (issuing as credits allow), HALT (no issue, waiting for redirect). Reset → RUN.
- inst_out/pc_out stable while inst_valid_out && !inst_ready_in.

## Timing
- Reset (rst_in low, asynchronous): fpc = RESET_PC, imem_addr_out = RESET_PC[ADDR_WIDTH+1:2], inst_valid_out 0, inst_out 0, pc_out 0, halted_out 0, FIFO empty, in-flight cleared, epoch 0. Reset mid-stream discards everything.
- Cycle 0 = first cycle after rst_in rises: RESET_PC address issued. Data sampled at end of cycle BRAM_LATENCY; inst_valid_out first high in cycle BRAM_LATENCY+1 (cycle 3 at default).
- Steady state with inst_ready_in held high: one instruction per cycle, consecutive PCs, no bubbles.
- Redirect at cycle t: inst_valid_out low in t+1 through t+BRAM_LATENCY+1; target instruction valid in cycle t+BRAM_LATENCY+2.
- inst_ready_in low for N cycles: at most FIFO_DEPTH buffered, issuing stops when credits reach 0, resumes the cycle after a pop; no instruction lost or duplicated.
- Redirect in the same cycle a stale word would be pushed: word discarded.

## Test plan
- Reset release, memory words 0..7 = 0x00100093+i, ready=1: valid from cycle 3, pc_out 0x0,0x4,…,0x1C in consecutive cycles, inst_out matches.
- Ready low cycles 4–13: exactly 4 entries buffered, no issue beyond credits; after ready rises, stream continues with no gap, skip, or duplicate.
- Redirect at cycle 6 to 0x0000_0042: pcs before redirect delivered in order, nothing stale after; next valid in cycle 10 with pc_out 0x40.
- Word at 0x10 = 0: instructions 0x0–0xC delivered, halted_out high, inst_valid_out low indefinitely; redirect to 0x0 restarts stream from 0x0.
- Redirect coincident with accepted handshake at pc 0x8: 0x8 counted consumed once, next delivered pc is the target.
- rst_in low mid-stream (asynchronous, between edges): all outputs return to reset values immediately; restart from RESET_PC.
